// File: rtl/stream_unpacker_if.sv
// Handshake bundle for stream_unpacker: a wide upstream word stream and a
// narrow downstream lane stream, seen from the unpacker (slave) or its environment (master).
interface stream_unpacker_if #(
    parameter int LW    = 8,
    parameter int LANES = 4
);
    localparam int CW = $clog2(LANES);

    logic                  i_valid;
    logic                  o_ready;
    logic [LANES*LW-1:0]   i_data;
    logic [CW-1:0]         i_count;
    logic                  o_valid;
    logic                  i_ready;
    logic [LW-1:0]         o_data;
    logic                  o_last;

    modport slave (
        input  i_valid, i_data, i_count, i_ready,
        output o_ready, o_valid, o_data, o_last
    );

    modport master (
        output i_valid, i_data, i_count, i_ready,
        input  o_ready, o_valid, o_data, o_last
    );
endinterface

// File: rtl/stream_unpacker.sv
// Splits a wide word of up to LANES lanes into a lane-per-beat stream, lane 0 first,
// accepting the next word in the same cycle the final lane drains.
module stream_unpacker #(
    parameter int LW    = 8,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    stream_unpacker_if.slave   bus
);
    localparam int CW = $clog2(LANES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [LANES*LW-1:0]   word_q, word_d;
    logic [CW-1:0]         last_q, last_d;
    logic [CW-1:0]         idx_q, idx_d;

    logic                  busy_s;
    logic                  at_last_s;
    logic                  ihs_s;
    logic                  ohs_s;
    logic [LW-1:0]         lane_s;

    assign busy_s    = (state_q == BUSY);
    assign at_last_s = (idx_q == last_q);
    assign ohs_s     = busy_s & bus.i_ready;
    // o_ready depends on i_ready so a new word can land while the last lane leaves
    assign ihs_s     = bus.i_valid & bus.o_ready;
    assign lane_s    = word_q[idx_q*LW +: LW];

    assign bus.o_ready = (state_q == IDLE) | (ohs_s & at_last_s);
    assign bus.o_valid = busy_s;
    assign bus.o_last  = busy_s & at_last_s;
    assign bus.o_data  = busy_s ? lane_s : {LW{1'b0}};

    // Next-state logic: load, advance lane index, or drain back to IDLE
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        last_d  = last_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (ihs_s) begin
                    state_d = BUSY;
                    word_d  = bus.i_data;
                    last_d  = bus.i_count;
                    idx_d   = {CW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (ohs_s) begin
                    if (!at_last_s) begin
                        idx_d = idx_q + CW'(1);
                    end else if (ihs_s) begin
                        word_d = bus.i_data;
                        last_d = bus.i_count;
                        idx_d  = {CW{1'b0}};
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= {(LANES*LW){1'b0}};
            last_q  <= {CW{1'b0}};
            idx_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_stream_unpacker.sv
// Self-checking bench for stream_unpacker: directed cycle table, reset sequences,
// and randomized traffic against a lane-queue reference model.
module tb_stream_unpacker;
    localparam int LW    = 8;
    localparam int LANES = 4;
    localparam int CW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stream_unpacker_if #(.LW(LW), .LANES(LANES)) bus ();
    stream_unpacker #(.LW(LW), .LANES(LANES)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [1:0]  c;
        logic        r;
        logic        ev;
        logic [7:0]  ed;
        logic        el;
        logic        er;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } lane_t;

    vec_t  tbl[$];
    lane_t mq[$];
    int    vectors    = 0;
    int    miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] c, input logic r);
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_count = c;
        bus.i_ready = r;
    endtask

    task automatic add(input logic v, input logic [31:0] d, input logic [1:0] c, input logic r,
                       input logic ev, input logic [7:0] ed, input logic el, input logic er);
        vec_t t;
        t.v = v; t.d = d; t.c = c; t.r = r;
        t.ev = ev; t.ed = ed; t.el = el; t.er = er;
        tbl.push_back(t);
    endtask

    // Reference: pending lanes of the held word; ready when nothing is left after this beat
    task automatic model_check(input string tag);
        logic       m_v, m_l, m_r;
        logic [7:0] m_d;
        m_v = (mq.size() != 0);
        m_d = m_v ? mq[0].d : 8'h00;
        m_l = m_v ? mq[0].l : 1'b0;
        m_r = !m_v || (mq.size() == 1 && bus.i_ready);
        chk({tag, ".o_valid"}, {31'd0, bus.o_valid}, {31'd0, m_v});
        chk({tag, ".o_data"},  {24'd0, bus.o_data},  {24'd0, m_d});
        chk({tag, ".o_last"},  {31'd0, bus.o_last},  {31'd0, m_l});
        chk({tag, ".o_ready"}, {31'd0, bus.o_ready}, {31'd0, m_r});
    endtask

    task automatic model_step();
        logic        ihs, ohs;
        logic [31:0] d;
        int          n;
        ohs = (mq.size() != 0) && bus.i_ready;
        ihs = bus.i_valid && ((mq.size() == 0) || (mq.size() == 1 && bus.i_ready));
        d   = bus.i_data;
        n   = int'(bus.i_count);
        @(posedge clk);
        if (ohs) void'(mq.pop_front());
        if (ihs) begin
            for (int k = 0; k <= n; k++) begin
                lane_t ln;
                ln.d = d[k*8 +: 8];
                ln.l = (k == n);
                mq.push_back(ln);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        // Directed cycle table, starting from IDLE
        add(1'b1, 32'h44332211, 2'd3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        add(1'b0, 32'h0,        2'd0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        add(1'b0, 32'h0,        2'd0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        add(1'b0, 32'h0,        2'd0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        add(1'b0, 32'h0,        2'd0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1);
        add(1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        // back-to-back words, no bubble
        add(1'b1, 32'hDDCCBBAA, 2'd3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        add(1'b1, 32'h00000099, 2'd0, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        add(1'b1, 32'h00000099, 2'd0, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0);
        add(1'b1, 32'h00000099, 2'd0, 1'b1, 1'b1, 8'hCC, 1'b0, 1'b0);
        add(1'b1, 32'h00000099, 2'd0, 1'b1, 1'b1, 8'hDD, 1'b1, 1'b1);
        add(1'b0, 32'h0,        2'd0, 1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
        add(1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        // backpressure at lane 1
        add(1'b1, 32'h44332211, 2'd3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        add(1'b0, 32'h0,        2'd0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        add(1'b0, 32'h0,        2'd0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        add(1'b0, 32'h0,        2'd0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        add(1'b0, 32'h0,        2'd0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        add(1'b0, 32'h0,        2'd0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        add(1'b0, 32'h0,        2'd0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        add(1'b0, 32'h0,        2'd0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1);
        // partial word, with a competing word offered while busy
        add(1'b1, 32'hFFEE0201, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        add(1'b1, 32'hA5A5A5A5, 2'd3, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        add(1'b1, 32'hA5A5A5A5, 2'd3, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
        add(1'b0, 32'h0,        2'd0, 1'b1, 1'b1, 8'h02, 1'b1, 1'b1);
        add(1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        // Reset state, with a word offered that must not be captured
        drive(1'b1, 32'hDEADBEEF, 2'd3, 1'b1);
        @(negedge clk);
        #1;
        chk("rst.o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst.o_data",  {24'd0, bus.o_data},  32'd0);
        chk("rst.o_last",  {31'd0, bus.o_last},  32'd0);
        chk("rst.o_ready", {31'd0, bus.o_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 2'd0, 1'b1);
        #1;
        chk("post_rst.o_valid", {31'd0, bus.o_valid}, 32'd0);
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].r);
            #1;
            chk($sformatf("tbl%0d.o_valid", i), {31'd0, bus.o_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("tbl%0d.o_data", i),  {24'd0, bus.o_data},  {24'd0, tbl[i].ed});
            chk($sformatf("tbl%0d.o_last", i),  {31'd0, bus.o_last},  {31'd0, tbl[i].el});
            chk($sformatf("tbl%0d.o_ready", i), {31'd0, bus.o_ready}, {31'd0, tbl[i].er});
            @(negedge clk);
        end

        // Asynchronous reset while lane 2 is pending
        drive(1'b1, 32'h44332211, 2'd3, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 2'd0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid.lane2", {24'd0, bus.o_data}, 32'h33);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst.o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("mid_rst.o_data",  {24'd0, bus.o_data},  32'd0);
        chk("mid_rst.o_last",  {31'd0, bus.o_last},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'h87654321, 2'd3, 1'b1);
        #1;
        chk("after_rst.o_ready", {31'd0, bus.o_ready}, 32'd1);
        chk("after_rst.o_valid", {31'd0, bus.o_valid}, 32'd0);
        @(negedge clk);
        drive(1'b0, 32'h0, 2'd0, 1'b1);
        #1;
        chk("after_rst.lane0", {24'd0, bus.o_data}, 32'h21);
        chk("after_rst.last",  {31'd0, bus.o_last}, 32'd0);
        repeat (4) @(negedge clk);

        // Randomized traffic against the queue model, with occasional resets
        mq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 700 == 699) begin
                rst = 1'b1;
                #1;
                chk("rnd_rst.o_valid", {31'd0, bus.o_valid}, 32'd0);
                chk("rnd_rst.o_data",  {24'd0, bus.o_data},  32'd0);
                mq.delete();
                @(negedge clk);
                rst = 1'b0;
            end
            drive(($urandom % 4) != 0, $urandom, 2'($urandom_range(0, 3)), ($urandom % 3) != 0);
            #1;
            model_check("rnd");
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
